// File: rtl/asip_alu_pkg.sv
// ---------------------------------------------------------------------------
// asip_alu_pkg
// Shared definitions for the ASIP ALU:
//   opcode_t       - 4-bit operation codes decoded from the Control port
//   FLAG_*         - bit positions of N/Z/C/V inside the Flags port
//   SH_*           - shift-mode selectors for asip_alu_shifter
// ---------------------------------------------------------------------------
package asip_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MOV  = 4'd10,
        OP_MAC  = 4'd11,
        OP_ADD3 = 4'd12,
        OP_CMP  = 4'd13,
        OP_SEL  = 4'd14,
        OP_NOP  = 4'd15
    } opcode_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] SH_LEFT        = 2'd0;
    localparam logic [1:0] SH_RIGHT_LOG   = 2'd1;
    localparam logic [1:0] SH_RIGHT_ARITH = 2'd2;

endpackage

// File: rtl/asip_alu_shifter.sv
// ---------------------------------------------------------------------------
// asip_alu_shifter
// Combinational barrel shifter with carry-out of the last bit shifted out.
// Ports:
//   a      - operand
//   sh     - shift amount (already reduced modulo ALUSize)
//   mode   - SH_LEFT / SH_RIGHT_LOG / SH_RIGHT_ARITH
//   result - shifted value
//   carry  - last bit shifted out, 0 when sh == 0
// ---------------------------------------------------------------------------
module asip_alu_shifter
    import asip_alu_pkg::*;
#(
    parameter int ALUSize = 32,
    localparam int SHW    = $clog2(ALUSize)
) (
    input  logic [ALUSize-1:0] a,
    input  logic [SHW-1:0]     sh,
    input  logic [1:0]         mode,
    output logic [ALUSize-1:0] result,
    output logic               carry
);

    // One guard bit beside the operand catches the last bit shifted out;
    // with sh == 0 the guard bit stays zero, giving carry = 0 for free.
    logic [ALUSize:0] left_ext;
    logic [ALUSize:0] right_ext;

    assign left_ext = {1'b0, a} << sh;

    always_comb begin
        if (mode == SH_RIGHT_ARITH) begin
            right_ext = $unsigned($signed({a, 1'b0}) >>> sh);
        end else begin
            right_ext = {a, 1'b0} >> sh;
        end
    end

    always_comb begin
        if (mode == SH_LEFT) begin
            result = left_ext[ALUSize-1:0];
            carry  = left_ext[ALUSize];
        end else begin
            result = right_ext[ALUSize:1];
            carry  = right_ext[0];
        end
    end

endmodule

// File: rtl/asip_alu.sv
// ---------------------------------------------------------------------------
// asip_alu
// Single-cycle ALU with a registered result and N/Z/C/V flags.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset (clears Result and Flags)
//   A, B, C - operands; B[log2(ALUSize)-1:0] is also the shift amount
//   Control - opcode (asip_alu_pkg::opcode_t)
//   Result  - registered result, 1-cycle latency
//   Flags   - registered {N,Z,C,V}
// CMP updates only Flags; NOP holds both registers.
// ---------------------------------------------------------------------------
module asip_alu
    import asip_alu_pkg::*;
#(
    parameter int ALUSize = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ALUSize-1:0] A,
    input  logic [ALUSize-1:0] B,
    input  logic [ALUSize-1:0] C,
    input  logic [3:0]         Control,
    output logic [ALUSize-1:0] Result,
    output logic [3:0]         Flags
);

    localparam int SHW = $clog2(ALUSize);
    localparam int MSB = ALUSize - 1;

    logic [ALUSize-1:0] result_reg, result_next;
    logic [3:0]         flags_reg, flags_next;

    logic [ALUSize:0]   add_ext;
    logic [ALUSize-1:0] sub_res;
    logic [ALUSize+1:0] add3_ext;
    logic [ALUSize-1:0] mul_res;
    logic [ALUSize-1:0] mac_res;
    logic [ALUSize-1:0] shift_res;
    logic               shift_carry;
    logic [1:0]         shift_mode;

    assign add_ext  = {1'b0, A} + {1'b0, B};
    assign sub_res  = A - B;
    // Two headroom bits: A+B+C can exceed 2^ALUSize by up to 2x.
    assign add3_ext = {2'b00, A} + {2'b00, B} + {2'b00, C};
    assign mul_res  = A * B;
    assign mac_res  = A * B + C;

    always_comb begin
        case (Control)
            OP_SHL:  shift_mode = SH_LEFT;
            OP_SRA:  shift_mode = SH_RIGHT_ARITH;
            default: shift_mode = SH_RIGHT_LOG;
        endcase
    end

    asip_alu_shifter #(
        .ALUSize (ALUSize)
    ) u_shifter (
        .a      (A),
        .sh     (B[SHW-1:0]),
        .mode   (shift_mode),
        .result (shift_res),
        .carry  (shift_carry)
    );

    logic [ALUSize-1:0] val;
    logic               c_bit;
    logic               v_bit;
    logic               update;
    logic               write_res;

    always_comb begin
        val         = result_reg;
        c_bit       = 1'b0;
        v_bit       = 1'b0;
        update      = 1'b1;
        write_res   = 1'b1;
        result_next = result_reg;
        flags_next  = flags_reg;

        case (Control)
            OP_ADD: begin
                val   = add_ext[MSB:0];
                c_bit = add_ext[ALUSize];
                v_bit = (A[MSB] == B[MSB]) && (add_ext[MSB] != A[MSB]);
            end
            OP_SUB, OP_CMP: begin
                val       = sub_res;
                c_bit     = (A >= B);
                v_bit     = (A[MSB] != B[MSB]) && (sub_res[MSB] != A[MSB]);
                write_res = (Control != OP_CMP);
            end
            OP_MUL:  val = mul_res;
            OP_AND:  val = A & B;
            OP_OR:   val = A | B;
            OP_XOR:  val = A ^ B;
            OP_NOT:  val = ~A;
            OP_SHL, OP_SHR, OP_SRA: begin
                val   = shift_res;
                c_bit = shift_carry;
            end
            OP_MOV:  val = A;
            OP_MAC:  val = mac_res;
            OP_ADD3: begin
                val   = add3_ext[MSB:0];
                c_bit = |add3_ext[ALUSize+1:ALUSize];
            end
            OP_SEL:  val = (C != '0) ? A : B;
            OP_NOP:  update = 1'b0;
            default: update = 1'b0;
        endcase

        if (update) begin
            flags_next[FLAG_N] = val[MSB];
            flags_next[FLAG_Z] = (val == '0);
            flags_next[FLAG_C] = c_bit;
            flags_next[FLAG_V] = v_bit;
            if (write_res) begin
                result_next = val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
            flags_reg  <= 4'b0000;
        end else begin
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

    assign Result = result_reg;
    assign Flags  = flags_reg;

endmodule

// File: tb/tb_asip_alu.sv
// ---------------------------------------------------------------------------
// tb_asip_alu
// Directed and random stimulus for asip_alu (ALUSize = 32). Each operation
// pushes its expected Result/Flags onto a scoreboard queue when driven; the
// entry is popped and compared one clock later when the DUT registers it.
// ---------------------------------------------------------------------------
module tb_asip_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] C = '0;
    logic [3:0]   Control = 4'd0;
    logic [W-1:0] Result;
    logic [3:0]   Flags;

    asip_alu #(.ALUSize(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .C       (C),
        .Control (Control),
        .Result  (Result),
        .Flags   (Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    exp_t   sb_q[$];
    string  tag_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;

    // Reference state: what the DUT registers should hold.
    logic [W-1:0] m_res = '0;
    logic [3:0]   m_flg = 4'b0000;

    // Independent reference model: wide integer arithmetic for carries and
    // signed overflow, bit-at-a-time loops for shifts.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] c,
                                   input logic [W-1:0] pr, input logic [3:0] pf);
        exp_t         e;
        logic [63:0]  wide;
        longint       sa, sb, sr;
        logic [W-1:0] r;
        logic         cy, ov;
        int           sh;
        r  = pr;
        cy = 1'b0;
        ov = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % W);
        case (op)
            4'd0: begin
                wide = {32'd0, a} + {32'd0, b};
                r = wide[W-1:0]; cy = (wide >= 64'h1_0000_0000);
                sr = sa + sb; ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1, 4'd13: begin
                r = a - b; cy = (a >= b);
                sr = sa - sb; ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2:  begin wide = {32'd0, a} * {32'd0, b}; r = wide[W-1:0]; end
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = ~a;
            4'd7:  begin r = a; for (int i = 0; i < sh; i++) begin cy = r[W-1]; r = {r[W-2:0], 1'b0}; end end
            4'd8:  begin r = a; for (int i = 0; i < sh; i++) begin cy = r[0]; r = {1'b0, r[W-1:1]}; end end
            4'd9:  begin r = a; for (int i = 0; i < sh; i++) begin cy = r[0]; r = {r[W-1], r[W-1:1]}; end end
            4'd10: r = a;
            4'd11: begin wide = {32'd0, a} * {32'd0, b} + {32'd0, c}; r = wide[W-1:0]; end
            4'd12: begin
                wide = {32'd0, a} + {32'd0, b} + {32'd0, c};
                r = wide[W-1:0]; cy = (wide >= 64'h1_0000_0000);
            end
            4'd14: r = (c != 0) ? a : b;
            default: ;
        endcase
        if (op == 4'd15) begin
            e.res = pr; e.flg = pf;
        end else begin
            e.flg = {r[W-1], (r == 0), cy, ov};
            e.res = (op == 4'd13) ? pr : r;
        end
        return e;
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (Result === e.res) else begin
            n_fail++;
            $error("FAIL %s result: got %h expected %h", t, Result, e.res);
        end
        n_cmp++;
        assert (Flags === e.flg) else begin
            n_fail++;
            $error("FAIL %s flags: got %b expected %b", t, Flags, e.flg);
        end
        $display("op %-10s ctl=%0d A=%h B=%h C=%h -> Result=%h Flags=%b",
                 t, Control, A, B, C, Result, Flags);
    endtask

    // Drive one op; if use_k, the expectation is the given constant,
    // otherwise it comes from the reference model.
    task automatic step(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit use_k, input logic [W-1:0] k_res,
                        input logic [3:0] k_flg, input string tag);
        exp_t e;
        A = a; B = b; C = c; Control = op;
        if (use_k) begin
            e.res = k_res; e.flg = k_flg;
        end else begin
            e = model(op, a, b, c, m_res, m_flg);
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
        m_res = e.res;
        m_flg = e.flg;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        assert (Result === '0) else begin
            n_fail++;
            $error("FAIL %s result: got %h expected 00000000", tag, Result);
        end
        n_cmp++;
        assert (Flags === 4'b0000) else begin
            n_fail++;
            $error("FAIL %s flags: got %b expected 0000", tag, Flags);
        end
        $display("chk %-10s reset=%b -> Result=%h Flags=%b", tag, reset, Result, Flags);
    endtask

    initial begin
        // Reset asserted between edges must clear outputs immediately.
        #1;
        A = 32'd5; B = 32'd7; C = '0; Control = 4'd0;
        reset = 1'b1;
        #1;
        check_zero("rst_imm");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset = 1'b0;
        m_res = '0; m_flg = 4'b0000;
        step(4'd0, 32'd5, 32'd7, 32'd0, 1, 32'd12, 4'b0000, "rst_add");

        // ADD overflow and carry
        step(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1, 32'h8000_0000, 4'b1001, "add_ovf");
        step(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'h0000_0000, 4'b0110, "add_cy");

        // SUB then CMP (Result held)
        step(4'd1, 32'd3, 32'd5, 32'd0, 1, 32'hFFFF_FFFE, 4'b1000, "sub");
        step(4'd13, 32'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFE, 4'b0110, "cmp");
        step(4'd15, 32'd9, 32'd9, 32'd9, 1, 32'hFFFF_FFFE, 4'b0110, "nop_flags");

        // Shifts, sh = 33 mod 32 = 1
        step(4'd8, 32'h8000_0001, 32'd33, 32'd0, 1, 32'h4000_0000, 4'b0010, "shr");
        step(4'd9, 32'h8000_0001, 32'd33, 32'd0, 1, 32'hC000_0000, 4'b1010, "sra");
        step(4'd7, 32'h8000_0001, 32'd33, 32'd0, 1, 32'h0000_0002, 4'b0010, "shl");
        step(4'd7, 32'h8000_0001, 32'd32, 32'd0, 1, 32'h8000_0001, 4'b1000, "shl_sh0");

        // Three-operand ops
        step(4'd11, 32'd3, 32'd4, 32'd5, 1, 32'd17, 4'b0000, "mac");
        step(4'd14, 32'd3, 32'd4, 32'd0, 1, 32'd4, 4'b0000, "sel_b");
        step(4'd15, 32'd3, 32'd4, 32'd0, 1, 32'd4, 4'b0000, "nop");
        step(4'd14, 32'd3, 32'd4, 32'd1, 1, 32'd3, 4'b0000, "sel_a");
        step(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 1, 32'h0000_0001, 4'b0010, "add3_cy");
        step(4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 32'h0000_0000, 4'b0100, "mul_wrap");

        // Mid-stream reset discards the in-flight op
        A = 32'd100; B = 32'd1; C = '0; Control = 4'd0;
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        #1;
        check_zero("mid_hold");
        reset = 1'b0;
        m_res = '0; m_flg = 4'b0000;
        step(4'd0, 32'd5, 32'd7, 32'd0, 1, 32'd12, 4'b0000, "post_rst");

        // Random ops checked against the reference model
        for (int i = 0; i < 48; i++) begin
            logic [3:0]   op;
            logic [W-1:0] ra, rb, rc;
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 70)) : $urandom;
            rc = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            step(op, ra, rb, rc, 0, '0, 4'b0000, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/asip_alu.md
ASIP_ALU -- requirements
Module: asip_alu

Interface
REQ-001 The block SHALL have parameter ALUSize, default 32, giving operand/result width in bits (legal: powers of two, 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port A, input, ALUSize bits: first operand.
REQ-005 The block SHALL have port B, input, ALUSize bits: second operand and shift amount.
REQ-006 The block SHALL have port C, input, ALUSize bits: third operand (accumulate / select).
REQ-007 The block SHALL have port Control, input, 4 bits: operation code.
REQ-008 The block SHALL have port Result, output, ALUSize bits: registered result.
REQ-009 The block SHALL have port Flags, output, 4 bits: registered {N,Z,C,V} (bit3 N, bit2 Z, bit1 C, bit0 V).

Function
REQ-010 Result and Flags SHALL update on the rising clk edge after inputs are presented, giving 1-cycle latency with no handshake; one operation SHALL be accepted per cycle.
REQ-011 Control SHALL decode as: 0 ADD A+B; 1 SUB A-B; 2 MUL low ALUSize bits of A*B; 3 AND; 4 OR; 5 XOR; 6 NOT ~A; 7 SHL A<<sh; 8 SHR logical A>>sh; 9 SRA arithmetic A>>>sh; 10 MOV A; 11 MAC low bits of A*B+C; 12 ADD3 A+B+C; 13 CMP; 14 SEL (C!=0 ? A : B); 15 NOP.
REQ-012 Shift amount sh SHALL be B[log2(ALUSize)-1:0]; upper B bits SHALL be ignored, so sh wraps modulo ALUSize.
REQ-013 All arithmetic SHALL be modulo 2^ALUSize; operands are unsigned except where signed interpretation is stated.
REQ-014 N SHALL be the MSB of the new result, and Z SHALL be 1 iff the new result is all zeros, for every opcode except NOP.
REQ-015 Flag C SHALL be: ADD the carry out; SUB/CMP 1 iff A>=B unsigned (no borrow); ADD3 1 iff the full-precision sum >= 2^ALUSize; SHL/SHR/SRA the last bit shifted out, or 0 when sh=0; all other opcodes 0.
REQ-016 Flag V SHALL be: ADD signed overflow (A,B same sign, result sign differs); SUB/CMP signed overflow (A,B different sign, result sign differs from A); all other opcodes 0.
REQ-017 CMP SHALL update Flags from A-B and leave Result unchanged.
REQ-018 NOP SHALL leave both Result and Flags unchanged.
REQ-019 MUL and MAC SHALL discard high product bits and report C=0, V=0.
REQ-020 There SHALL be no internal state other than the Result and Flags registers; no multi-cycle operations.

Reset
REQ-021 While reset=1, Result SHALL be 0 and Flags SHALL be 4'b0000, immediately and independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight operation; the first edge after deassertion SHALL register the operation presented on that edge.

Structure
REQ-023 A shared package asip_alu_pkg SHALL hold the 4-bit opcode enum (values per REQ-011) and the flag bit-index constants (N=3, Z=2, C=1, V=0).
REQ-024 The shift logic (SHL/SHR/SRA with carry-out) SHALL be one sub-module, asip_alu_shifter; all else SHALL be a combinational next-value block plus the output register.

Verification
REQ-025 Reset: assert reset with Control=0, A=5, B=7 -> Result=0 and Flags=0 immediately; after deassertion, the next edge gives Result=12 and Flags=0000.
REQ-026 ADD overflow (ALUSize=32): A=0x7FFFFFFF, B=1, Control=0 -> Result=0x80000000, Flags=1001; A=0xFFFFFFFF, B=1 -> Result=0, Flags=0110.
REQ-027 SUB/CMP: A=3, B=5, Control=1 -> Result=0xFFFFFFFE, Flags=1000; then Control=13 with A=5, B=5 -> Result stays 0xFFFFFFFE, Flags=0110.
REQ-028 Shifts: A=0x80000001, B=33 (sh=1), Control=8 -> Result=0x40000000, C=1; Control=9 -> Result=0xC0000000, Flags=1010; Control=7 -> Result=0x00000002, C=1.
REQ-029 3-operand: A=3, B=4, C=5, Control=11 -> Result=17; Control=14 with C=0 -> Result=4; Control=15 -> Result and Flags hold their prior values.
